// File: rtl/qam_demodulator.sv
// 16-QAM correlating demodulator.
// Correlates the received stream against the I/Q carrier references over one
// symbol, accumulates the carrier energies alongside, and slices each axis
// into sign + magnitude (+/-1 or +/-3) to rebuild the modulator's 4-bit code.
// Three register stages: products -> accumulators -> decision.
module qam_demodulator #(
  parameter int SAMPLES_PER_SYMBOL = 16,
  parameter int CNT_W              = 4,
  parameter int ACC_W              = 44
) (
  input  logic                ipClk,
  input  logic                ipReset,
  input  logic signed [19:0]  ipModulated,
  input  logic                ipModulatedValid,
  input  logic signed [17:0]  ipI,
  input  logic signed [17:0]  ipQ,
  input  logic                ipSymbolStart,
  output logic [3:0]          opQAMStream,
  output logic                opQAMValid,
  output logic                opAbort
);

  typedef enum logic {IDLE, ACQ} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, pos;
  logic                    accept, first_d, last_d, abort_d;

  // stage 1
  logic signed [37:0]      pI, pQ, pI_q, pQ_q;
  logic signed [35:0]      eI, eQ, eI_q, eQ_q;
  logic                    first1_q, last1_q;
  // stage 2
  logic [ACC_W-1:0]        accI_q, accQ_q, enI_q, enQ_q;
  logic [ACC_W-1:0]        accI_d, accQ_d, enI_d, enQ_d;
  logic [ACC_W-1:0]        addI, addQ, addEI, addEQ;
  logic                    last2_q;
  // [1] stage-1 data valid, [2] stage-2 accumulators updated
  logic [2:1]              vld_pipe_q;
  // stage 3
  logic [ACC_W-1:0]        absI, absQ;
  logic                    magI, magQ;
  logic [3:0]              code_d, code_q;
  logic                    valid_q, abort_q;

  // Symbol framing: decide whether the sample is taken and where it sits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    abort_d = 1'b0;
    // a start always realigns to position 0
    pos     = ipSymbolStart ? '0 : cnt_q;
    if (ipModulatedValid && (ipSymbolStart || state_q == ACQ)) begin
      accept  = 1'b1;
      state_d = ACQ;
      first_d = (pos == '0);
      last_d  = (pos == CNT_W'(SAMPLES_PER_SYMBOL - 1));
      cnt_d   = last_d ? '0 : pos + 1'b1;
      abort_d = ipSymbolStart && (state_q == ACQ) && (cnt_q != '0);
    end
  end

  // FSM state and sample counter.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pI = 38'(ipModulated) * 38'(ipI);
  assign pQ = 38'(ipModulated) * 38'(ipQ);
  assign eI = 36'(ipI) * 36'(ipI);
  assign eQ = 36'(ipQ) * 36'(ipQ);

  // Stage 1: register products only for accepted samples; hold otherwise.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      pI_q     <= '0;
      pQ_q     <= '0;
      eI_q     <= '0;
      eQ_q     <= '0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
    end else if (accept) begin
      pI_q     <= pI;
      pQ_q     <= pQ;
      eI_q     <= eI;
      eQ_q     <= eQ;
      first1_q <= first_d;
      last1_q  <= last_d;
    end
  end

  assign addI  = {{(ACC_W-38){pI_q[37]}}, pI_q};
  assign addQ  = {{(ACC_W-38){pQ_q[37]}}, pQ_q};
  assign addEI = {{(ACC_W-36){1'b0}}, eI_q};
  assign addEQ = {{(ACC_W-36){1'b0}}, eQ_q};

  // Stage 2 next state: first sample of a symbol loads, the rest add.
  always_comb begin
    accI_d = accI_q;
    accQ_d = accQ_q;
    enI_d  = enI_q;
    enQ_d  = enQ_q;
    if (vld_pipe_q[1]) begin
      accI_d = first1_q ? addI  : accI_q + addI;
      accQ_d = first1_q ? addQ  : accQ_q + addQ;
      enI_d  = first1_q ? addEI : enI_q  + addEI;
      enQ_d  = first1_q ? addEQ : enQ_q  + addEQ;
    end
  end

  // Stage 2 accumulators and the valid shift register.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      accI_q     <= '0;
      accQ_q     <= '0;
      enI_q      <= '0;
      enQ_q      <= '0;
      last2_q    <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      accI_q     <= accI_d;
      accQ_q     <= accQ_d;
      enI_q      <= enI_d;
      enQ_q      <= enQ_d;
      vld_pipe_q <= {vld_pipe_q[1], accept};
      if (vld_pipe_q[1]) last2_q <= last1_q;
    end
  end

  // Slicer: sign bit from the correlation, magnitude 3 only if |acc| > 2*energy.
  always_comb begin
    absI   = accI_q[ACC_W-1] ? (~accI_q + 1'b1) : accI_q;
    absQ   = accQ_q[ACC_W-1] ? (~accQ_q + 1'b1) : accQ_q;
    magI   = {1'b0, absI} > {enI_q, 1'b0};
    magQ   = {1'b0, absQ} > {enQ_q, 1'b0};
    code_d = {accQ_q[ACC_W-1], magQ, accI_q[ACC_W-1], magI};
    if (enI_q == '0 || enQ_q == '0) code_d = 4'b0000;
  end

  // Stage 3: latch the decision on a completed symbol; strobes last one cycle.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      valid_q <= vld_pipe_q[2] && last2_q;
      abort_q <= abort_d;
      if (vld_pipe_q[2] && last2_q) code_q <= code_d;
    end
  end

  assign opQAMStream = code_q;
  assign opQAMValid  = valid_q;
  assign opAbort     = abort_q;

endmodule
